// File: rtl/sprite_draw_arbiter.sv
// Round-robin arbiter for three sprite engines sharing one VGA plot port.
// The granted rectangle is rasterised row-major, one pixel per clock, with off-screen pixels suppressed.
module sprite_draw_arbiter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [23:0] req_x,
    input  logic [20:0] req_y,
    input  logic [11:0] req_w,
    input  logic [11:0] req_h,
    input  logic [8:0]  req_colour,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        busy
);

    // state  | meaning
    // S_IDLE | waiting for any request, round-robin search from r_ptr
    // S_LOAD | latch granted rectangle, first pixel prepared on exit
    // S_SCAN | one pixel per cycle on the vga_* outputs
    // S_DONE | one-cycle done pulse, pointer moved past the served engine
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_t;

    localparam logic [8:0] LP_W = 9'(SCREEN_W);
    localparam logic [7:0] LP_H = 8'(SCREEN_H);

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [1:0] r_g;
    logic [7:0] r_bx;
    logic [6:0] r_by;
    logic [3:0] r_wl;
    logic [3:0] r_hl;
    logic [3:0] r_cx;
    logic [3:0] r_cy;

    logic [1:0] w_p1;
    logic [1:0] w_p2;
    logic [1:0] w_sel;
    logic       w_any;
    logic [7:0] w_fx;
    logic [6:0] w_fy;
    logic [3:0] w_fw;
    logic [3:0] w_fh;
    logic [2:0] w_fc;
    logic [7:0] w_bx;
    logic [6:0] w_by;
    logic [3:0] w_nx;
    logic [3:0] w_ny;
    logic [8:0] w_px;
    logic [7:0] w_py;
    logic       w_vis;
    logic       w_last;

    function automatic logic [1:0] f_inc3(input logic [1:0] a);
        return (a == 2'd2) ? 2'd0 : a + 2'd1;
    endfunction

    // Later assignments win, so the engine closest to r_ptr is chosen.
    always_comb begin
        w_p1  = f_inc3(r_ptr);
        w_p2  = f_inc3(w_p1);
        w_any = |req;
        w_sel = r_ptr;
        if (req[w_p2])  w_sel = w_p2;
        if (req[w_p1])  w_sel = w_p1;
        if (req[r_ptr]) w_sel = r_ptr;
    end

    always_comb begin
        w_fx = req_x[7:0];
        w_fy = req_y[6:0];
        w_fw = req_w[3:0];
        w_fh = req_h[3:0];
        w_fc = req_colour[2:0];
        case (r_g)
            2'd1: begin
                w_fx = req_x[15:8];
                w_fy = req_y[13:7];
                w_fw = req_w[7:4];
                w_fh = req_h[7:4];
                w_fc = req_colour[5:3];
            end
            2'd2: begin
                w_fx = req_x[23:16];
                w_fy = req_y[20:14];
                w_fw = req_w[11:8];
                w_fh = req_h[11:8];
                w_fc = req_colour[8:6];
            end
            default: ;
        endcase
    end

    // Coordinates of the pixel that will be on the outputs next cycle.
    always_comb begin
        w_last = (r_cx == r_wl) && (r_cy == r_hl);
        w_bx   = r_bx;
        w_by   = r_by;
        w_nx   = 4'd0;
        w_ny   = 4'd0;
        if (r_state == S_LOAD) begin
            w_bx = w_fx;
            w_by = w_fy;
        end else if (r_cx == r_wl) begin
            w_ny = r_cy + 4'd1;
        end else begin
            w_nx = r_cx + 4'd1;
            w_ny = r_cy;
        end
        w_px  = {1'b0, w_bx} + {5'd0, w_nx};
        w_py  = {1'b0, w_by} + {4'd0, w_ny};
        w_vis = (w_px < LP_W) && (w_py < LP_H);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= 2'd0;
            r_g        <= 2'd0;
            r_bx       <= 8'd0;
            r_by       <= 7'd0;
            r_wl       <= 4'd0;
            r_hl       <= 4'd0;
            r_cx       <= 4'd0;
            r_cy       <= 4'd0;
            grant      <= 3'd0;
            done       <= 3'd0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= S_LOAD;
                        r_g     <= w_sel;
                        grant   <= 3'b001 << w_sel;
                        busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state    <= S_SCAN;
                    r_bx       <= w_fx;
                    r_by       <= w_fy;
                    r_wl       <= (w_fw == 4'd0) ? 4'd0 : w_fw - 4'd1;
                    r_hl       <= (w_fh == 4'd0) ? 4'd0 : w_fh - 4'd1;
                    r_cx       <= 4'd0;
                    r_cy       <= 4'd0;
                    vga_x      <= w_px[7:0];
                    vga_y      <= w_py[6:0];
                    vga_colour <= w_fc;
                    vga_plot   <= w_vis;
                end
                S_SCAN: begin
                    if (w_last) begin
                        r_state  <= S_DONE;
                        grant    <= 3'd0;
                        done     <= grant;
                        vga_plot <= 1'b0;
                        r_ptr    <= f_inc3(r_g);
                    end else begin
                        r_cx     <= w_nx;
                        r_cy     <= w_ny;
                        vga_x    <= w_px[7:0];
                        vga_y    <= w_py[6:0];
                        vga_plot <= w_vis;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 3'd0;
                    busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Bench for sprite_draw_arbiter: vector table, corner-case sequences and random multi-requester rounds
// checked against a rectangle/round-robin model that tracks each requester and the search pointer.
module tb_sprite_draw_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  r_req;
    logic [7:0]  fx[3];
    logic [6:0]  fy[3];
    logic [3:0]  fw[3];
    logic [3:0]  fh[3];
    logic [2:0]  fc[3];
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [11:0] req_w;
    logic [11:0] req_h;
    logic [8:0]  req_colour;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int m_ptr = 0;
    int last_g, last_scan, last_plots, last_lat;

    assign req_x      = {fx[2], fx[1], fx[0]};
    assign req_y      = {fy[2], fy[1], fy[0]};
    assign req_w      = {fw[2], fw[1], fw[0]};
    assign req_h      = {fh[2], fh[1], fh[0]};
    assign req_colour = {fc[2], fc[1], fc[0]};

    sprite_draw_arbiter dut (
        .clk(clk), .reset(reset), .req(r_req),
        .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h), .req_colour(req_colour),
        .grant(grant), .done(done), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_fields(input int g, input int x, input int y, input int w, input int h, input int c);
        fx[g] = 8'(x); fy[g] = 7'(y); fw[g] = 4'(w); fh[g] = 4'(h); fc[g] = 3'(c);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_grant"}, grant, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_x"}, vga_x, 0);
        chk({nm, "_y"}, vga_y, 0);
        chk({nm, "_col"}, vga_colour, 0);
        chk({nm, "_plot"}, vga_plot, 0);
        chk({nm, "_busy"}, busy, 0);
    endtask

    // Entered and left on the negedge of an IDLE cycle; the model picks who should be granted.
    task automatic serve(input bit drop, input bit scramble);
        int g, bx, by, w, h, col, n, ex, ey;
        bit ep;
        n = 0;
        while (busy !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        if (busy !== 1'b0) begin chk("idle_timeout", busy, 0); return; end
        g = -1;
        for (int k = 0; k < 3; k++)
            if (g < 0 && r_req[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
        if (g < 0) return;
        bx = fx[g]; by = fy[g]; col = fc[g];
        w = (fw[g] == 0) ? 1 : int'(fw[g]);
        h = (fh[g] == 0) ? 1 : int'(fh[g]);
        @(negedge clk);
        chk("load_grant", grant, 3'b001 << g);
        chk("load_plot", vga_plot, 0);
        chk("load_busy", busy, 1);
        last_scan = 0; last_plots = 0;
        for (int p = 0; p < w * h; p++) begin
            @(negedge clk);
            ex = bx + p % w;
            ey = by + p / w;
            ep = (ex < 160) && (ey < 120);
            if (grant === (3'b001 << g)) last_scan++;
            if (vga_plot === 1'b1) last_plots++;
            chk("scan_plot", vga_plot, ep);
            chk("scan_done", done, 0);
            if (ep) begin
                chk("scan_x", vga_x, ex);
                chk("scan_y", vga_y, ey);
                chk("scan_col", vga_colour, col);
            end
            if (p == 0 && scramble) begin
                set_fields(g, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 15),
                           $urandom_range(0, 15), $urandom_range(0, 7));
                r_req[g] = 1'b0;
            end
        end
        last_lat = -1;
        for (int k = 1; k <= 3 && last_lat < 0; k++) begin
            @(negedge clk);
            if (done !== 3'd0) last_lat = 1 + w * h + k;
        end
        chk("done_val", done, 3'b001 << g);
        chk("done_grant", grant, 0);
        chk("done_plot", vga_plot, 0);
        chk("done_lat", last_lat, 2 + w * h);
        if (drop) r_req[g] = 1'b0;
        m_ptr = (g + 1) % 3;
        last_g = g;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
    endtask

    typedef struct {
        int g, x, y, w, h, c;
        int exp_scan, exp_plots;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs = '{
            '{1,  10,  20,  2,  3, 7,   6,   6},
            '{0, 158, 119,  4,  2, 5,   8,   2},
            '{2,   0,   0,  0,  0, 3,   1,   1},
            '{0, 255, 127, 15, 15, 1, 225,   0},
            '{2, 150, 110, 15, 15, 6, 225, 100},
            '{1, 159,   0,  1,  1, 2,   1,   1}
        };
        reset = 1'b0;
        r_req = 3'd0;
        for (int i = 0; i < 3; i++) set_fields(i, 0, 0, 1, 1, 0);
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            set_fields(vecs[i].g, vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].c);
            r_req = 3'b001 << vecs[i].g;
            serve(1'b1, 1'b0);
            chk("vec_g", last_g, vecs[i].g);
            chk("vec_scan", last_scan, vecs[i].exp_scan);
            chk("vec_plots", last_plots, vecs[i].exp_plots);
            chk("vec_lat", last_lat, vecs[i].exp_scan + 2);
        end

        // Move the pointer off zero, then reset in the middle of requester 1's scan.
        set_fields(0, 5, 5, 1, 1, 1);
        r_req = 3'b001;
        serve(1'b1, 1'b0);
        set_fields(1, 30, 30, 4, 4, 4);
        r_req = 3'b010;
        @(negedge clk);
        chk("mid_load_grant", grant, 3'b010);
        repeat (5) @(negedge clk);
        chk("mid_plot5", vga_plot, 1);
        reset = 1'b0;
        r_req = 3'b111;
        for (int i = 0; i < 3; i++) set_fields(i, 40 + i, 50, 1, 1, i + 1);
        @(negedge clk);
        chk_all_zero("midreset");
        reset = 1'b1;
        m_ptr = 0;

        // All three held with 1x1 rectangles: back-to-back grants 0,1,2,0.
        serve(1'b0, 1'b0); chk("rr_first", last_g, 0);
        serve(1'b0, 1'b0); chk("rr_second", last_g, 1);
        serve(1'b0, 1'b0); chk("rr_third", last_g, 2);
        serve(1'b0, 1'b0); chk("rr_fourth", last_g, 0);
        r_req = 3'd0;
        @(negedge clk);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 3; i++)
                set_fields(i, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 15),
                           $urandom_range(0, 6), $urandom_range(0, 7));
            r_req = 3'($urandom_range(1, 7));
            for (int k = 0; k < 4 && r_req != 3'd0; k++) serve(1'b1, 1'($urandom_range(0, 1)));
            chk("rand_drained", r_req, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
